dvp_frame_gen: RTL and testbench

//   On-chip DVP camera source: emits OV7670-style RGB565 frames (VSYNC/HREF/PCLK/8-bit data)
//   on the same interface the ML-mode frame capture consumes. Drives capture-path BIST and

---
 rtl/dvp_frame_gen.sv | 200 ++++++++++++++++++++
 tb/tb_dvp_frame_gen.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_frame_gen.sv
// OV7670-style RGB565 DVP frame source with built-in test patterns.
// Every visible change happens on the slot boundary, so bytes are stable across each rising cam_pclk.
module dvp_frame_gen #(
  parameter int H_PIXELS = 20,
  parameter int V_ROWS   = 10,
  parameter int VS_LEAD  = 5,
  parameter int H_BLANK  = 5,
  parameter int V_BLANK  = 20,
  parameter int PCLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        continuous,
  input  logic [1:0]  pattern,
  input  logic [15:0] color_in,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic        cam_pclk,
  output logic [7:0]  cam_data,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frame_count
);

  localparam int ACT_SLOTS = 2 * H_PIXELS;
  localparam int MAX_AB    = (ACT_SLOTS > VS_LEAD) ? ACT_SLOTS : VS_LEAD;
  localparam int MAX_CD    = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int SLOT_MAX  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW        = $clog2(SLOT_MAX + 1);
  localparam int DW        = $clog2(PCLK_DIV);
  localparam int XW        = $clog2(H_PIXELS);
  localparam int YW        = (V_ROWS > 1) ? $clog2(V_ROWS) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEAD   = 3'd1,
    S_ACTIVE = 3'd2,
    S_HBLANK = 3'd3,
    S_VBLANK = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [DW-1:0] div;
  logic          slot_end;
  logic [CW-1:0] slot_cnt, cnt_nx;
  logic [YW-1:0] y, y_nx;
  logic          pending, pending_nx;
  logic          latch_cfg;
  logic          done_nx;
  logic [1:0]    pat_q;
  logic [15:0]   color_q;
  logic [XW-1:0] x;
  logic          byte_sel;
  logic [4:0]    x5;
  logic [5:0]    y6;
  logic [15:0]   pix;

  // Free-running slot divider; wraps to 0 on the slot boundary in every state.
  assign slot_end = (div == DW'(PCLK_DIV - 1));
  assign cam_pclk = (div >= DW'(PCLK_DIV / 2));

  always_ff @(posedge clk) begin
    if (rst) div <= '0;
    else if (slot_end) div <= '0;
    else div <= div + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      slot_cnt    <= '0;
      y           <= '0;
      pending     <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 8'd0;
      pat_q       <= 2'd0;
      color_q     <= 16'h0000;
    end else begin
      state       <= state_nx;
      slot_cnt    <= cnt_nx;
      y           <= y_nx;
      pending     <= pending_nx;
      frame_done  <= done_nx;
      frame_count <= frame_count + {7'd0, done_nx};
      if (latch_cfg) begin
        pat_q   <= pattern;
        color_q <= color_in;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = slot_cnt;
    y_nx       = y;
    pending_nx = pending;
    latch_cfg  = 1'b0;
    done_nx    = 1'b0;
    case (state)
      S_IDLE: begin
        // Request is taken on any edge; the frame itself starts on a slot boundary.
        if (pending) begin
          if (slot_end) begin
            state_nx   = S_LEAD;
            cnt_nx     = '0;
            pending_nx = 1'b0;
            latch_cfg  = 1'b1;
          end
        end else if (start || continuous) begin
          pending_nx = 1'b1;
        end
      end
      S_LEAD: begin
        if (slot_end) begin
          if (slot_cnt == CW'(VS_LEAD - 1)) begin
            state_nx = S_ACTIVE;
            cnt_nx   = '0;
            y_nx     = '0;
          end else begin
            cnt_nx = slot_cnt + CW'(1);
          end
        end
      end
      S_ACTIVE: begin
        if (slot_end) begin
          if (slot_cnt == CW'(ACT_SLOTS - 1)) begin
            state_nx = S_HBLANK;
            cnt_nx   = '0;
          end else begin
            cnt_nx = slot_cnt + CW'(1);
          end
        end
      end
      S_HBLANK: begin
        if (slot_end) begin
          if (slot_cnt == CW'(H_BLANK - 1)) begin
            cnt_nx = '0;
            if (y == YW'(V_ROWS - 1)) begin
              state_nx = S_VBLANK;
            end else begin
              state_nx = S_ACTIVE;
              y_nx     = y + YW'(1);
            end
          end else begin
            cnt_nx = slot_cnt + CW'(1);
          end
        end
      end
      S_VBLANK: begin
        if (slot_end) begin
          if (slot_cnt == CW'(V_BLANK - 1)) begin
            done_nx = 1'b1;
            cnt_nx  = '0;
            if (continuous) begin
              state_nx  = S_LEAD;
              latch_cfg = 1'b1;
            end else begin
              state_nx = S_IDLE;
            end
          end else begin
            cnt_nx = slot_cnt + CW'(1);
          end
        end
      end
      default: begin
        state_nx   = S_IDLE;
        cnt_nx     = '0;
        pending_nx = 1'b0;
      end
    endcase
  end

  // Within a row the slot counter doubles as {pixel x, byte select}.
  assign x        = slot_cnt[XW:1];
  assign byte_sel = slot_cnt[0];
  assign x5       = 5'(x);
  assign y6       = 6'(y);

  always_comb begin
    pix = 16'h0000;
    case (pat_q)
      2'd0: pix = color_q;
      2'd1: begin
        if (x < XW'(H_PIXELS / 4))              pix = 16'hF800;
        else if (x < XW'(H_PIXELS / 2))         pix = 16'h07E0;
        else if (x < XW'((3 * H_PIXELS) / 4))   pix = 16'h001F;
        else                                    pix = 16'hFFFF;
      end
      2'd2: pix = {x5, y6, x5 ^ y6[4:0]};
      default: pix = (x5[2] ^ y6[2]) ? color_q : 16'h0000;
    endcase
  end

  assign cam_href  = (state == S_ACTIVE);
  assign cam_vsync = (state == S_LEAD) || (state == S_ACTIVE) || (state == S_HBLANK);
  assign cam_data  = cam_href ? (byte_sel ? pix[7:0] : pix[15:8]) : 8'h00;
  assign busy      = pending || (state != S_IDLE);

endmodule

// File: tb/tb_dvp_frame_gen.sv
// Directed bench for dvp_frame_gen: byte scoreboard, slot-stability monitor and frame timing checks.
module tb_dvp_frame_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic        continuous;
  logic [1:0]  pattern;
  logic [15:0] color_in;
  logic        cam_vsync;
  logic        cam_href;
  logic        cam_pclk;
  logic [7:0]  cam_data;
  logic        busy;
  logic        frame_done;
  logic [7:0]  frame_count;

  dvp_frame_gen dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .continuous  (continuous),
    .pattern     (pattern),
    .color_in    (color_in),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_pclk    (cam_pclk),
    .cam_data    (cam_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [7:0] exp_q[$];
  logic [7:0] cap [0:9][0:39];
  logic       mon_en = 1'b0;
  int         rows = 0;
  int         byte_cnt = 0;
  int         stable_err = 0;
  int         idle_err = 0;
  int         fd_total = 0;
  int         vs_rise_cyc = 0;
  logic       href_slot_q = 1'b0;
  logic       pclk_q = 1'b0;
  logic       vs_q = 1'b0;
  logic       fd_q = 1'b0;
  logic [9:0] out_q = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_pix(input logic [1:0] pat, input logic [15:0] col,
                                          input int x, input int y);
    logic [4:0] xv;
    logic [5:0] yv;
    xv = x[4:0];
    yv = y[5:0];
    case (pat)
      2'd0: return col;
      2'd1: begin
        if (x < 5)       return 16'hF800;
        else if (x < 10) return 16'h07E0;
        else if (x < 15) return 16'h001F;
        else             return 16'hFFFF;
      end
      2'd2: return {xv, yv, xv ^ yv[4:0]};
      default: return (xv[2] ^ yv[2]) ? col : 16'h0000;
    endcase
  endfunction

  // driver tasks
  task automatic push_frame(input logic [1:0] pat, input logic [15:0] col);
    logic [15:0] p;
    for (int yy = 0; yy < 10; yy++) begin
      for (int xx = 0; xx < 20; xx++) begin
        p = exp_pix(pat, col, xx, yy);
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[7:0]);
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_stats();
    rows       = 0;
    byte_cnt   = 0;
    stable_err = 0;
    idle_err   = 0;
  endtask

  task automatic wait_fd(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!frame_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, {31'd0, frame_done}, 32'd1);
  endtask

  task automatic end_of_frame(input string tag, input int exp_rows);
    repeat (4) @(negedge clk);
    check({tag, "_queue_left"}, exp_q.size(), 0);
    check({tag, "_rows"}, rows, exp_rows);
    check({tag, "_stable"}, stable_err, 0);
    check({tag, "_idle_data"}, idle_err, 0);
  endtask

  // monitor: samples on the falling clk edge, bytes taken where cam_pclk rises
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (frame_done) begin
          fd_total++;
          check("fd_latency", cyc - vs_rise_cyc, 950);
          check("fd_width", {31'd0, fd_q}, 32'd0);
        end
        if (cam_vsync && !vs_q) vs_rise_cyc = cyc;
        if ({cam_vsync, cam_href, cam_data} != out_q && !(pclk_q && !cam_pclk)) stable_err++;
        if (!cam_href && cam_data != 8'h00) idle_err++;
        if (cam_pclk && !pclk_q) begin
          if (cam_href) begin
            if (!href_slot_q) begin
              rows++;
              byte_cnt = 0;
            end
            if (exp_q.size() == 0) begin
              check("byte_extra", {24'd0, cam_data}, 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              check("byte", {24'd0, cam_data}, {24'd0, e});
            end
            if (rows >= 1 && rows <= 10 && byte_cnt < 40) cap[rows-1][byte_cnt] = cam_data;
            byte_cnt++;
          end else if (href_slot_q) begin
            check("row_len", byte_cnt, 40);
          end
          href_slot_q = cam_href;
        end
      end
      pclk_q = cam_pclk;
      vs_q   = cam_vsync;
      fd_q   = frame_done;
      out_q  = {cam_vsync, cam_href, cam_data};
    end
  end

  initial begin
    int quiet_err;
    int fd_before;
    int n;
    rst        = 1'b1;
    start      = 1'b0;
    continuous = 1'b0;
    pattern    = 2'd0;
    color_in   = 16'h0000;

    // 1: reset and idle behaviour
    repeat (5) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t1_pclk_phase", {31'd0, cam_pclk}, i % 2);
      @(negedge clk);
    end
    quiet_err = 0;
    repeat (46) begin
      if (cam_vsync || cam_href || cam_data != 0 || busy || frame_done || frame_count != 0)
        quiet_err++;
      @(negedge clk);
    end
    check("t1_idle_quiet", quiet_err, 0);
    check("t1_vsync", {31'd0, cam_vsync}, 0);
    check("t1_count", {24'd0, frame_count}, 0);
    check("t1_busy", {31'd0, busy}, 0);

    // 2: solid colour frame
    clear_stats();
    pattern  = 2'd0;
    color_in = 16'h47F0;
    push_frame(2'd0, 16'h47F0);
    pulse_start();
    check("t2_busy_after_start", {31'd0, busy}, 1);
    wait_fd("t2", 1200);
    check("t2_count", {24'd0, frame_count}, 1);
    check("t2_busy_at_done", {31'd0, busy}, 0);
    check("t2_vsync_at_done", {31'd0, cam_vsync}, 0);
    end_of_frame("t2", 10);

    // 3: colour bars
    clear_stats();
    pattern = 2'd1;
    push_frame(2'd1, 16'h0000);
    pulse_start();
    wait_fd("t3", 1200);
    check("t3_count", {24'd0, frame_count}, 2);
    end_of_frame("t3", 10);
    check("t3_row9_px0_hi", {24'd0, cap[9][0]}, 32'hF8);
    check("t3_row9_px10_lo", {24'd0, cap[9][21]}, 32'h1F);

    // 4: continuous frames, mid-frame start ignored
    clear_stats();
    pattern  = 2'd0;
    color_in = 16'h1357;
    fd_before = fd_total;
    push_frame(2'd0, 16'h1357);
    push_frame(2'd0, 16'h1357);
    push_frame(2'd0, 16'h1357);
    continuous = 1'b1;
    wait_fd("t4_f1", 1200);
    check("t4_f1_vsync_same_edge", {31'd0, cam_vsync}, 1);
    check("t4_f1_busy", {31'd0, busy}, 1);
    check("t4_f1_count", {24'd0, frame_count}, 3);
    repeat (400) @(negedge clk);
    pulse_start();
    wait_fd("t4_f2", 1200);
    check("t4_f2_vsync_same_edge", {31'd0, cam_vsync}, 1);
    check("t4_f2_count", {24'd0, frame_count}, 4);
    repeat (100) @(negedge clk);
    continuous = 1'b0;
    wait_fd("t4_f3", 1200);
    check("t4_f3_vsync", {31'd0, cam_vsync}, 0);
    check("t4_f3_busy", {31'd0, busy}, 0);
    check("t4_f3_count", {24'd0, frame_count}, 5);
    repeat (1100) @(negedge clk);
    check("t4_frames", fd_total - fd_before, 3);
    end_of_frame("t4", 30);

    // 5: gradient, pattern change mid-frame takes effect only next frame
    clear_stats();
    pattern  = 2'd2;
    color_in = 16'h0000;
    push_frame(2'd2, 16'h0000);
    pulse_start();
    repeat (300) @(negedge clk);
    pattern  = 2'd0;
    color_in = 16'hFFFF;
    wait_fd("t5_f1", 1200);
    end_of_frame("t5_f1", 10);
    check("t5_row3_px7_hi", {24'd0, cap[3][14]}, 32'h38);
    check("t5_row3_px7_lo", {24'd0, cap[3][15]}, 32'h64);
    clear_stats();
    push_frame(2'd0, 16'hFFFF);
    pulse_start();
    wait_fd("t5_f2", 1200);
    check("t5_count", {24'd0, frame_count}, 7);
    end_of_frame("t5_f2", 10);

    // 6: reset mid-row aborts the frame
    rst = 1'b1;
    mon_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_stats();
    href_slot_q = 1'b0;
    mon_en = 1'b1;
    pattern  = 2'd3;
    color_in = 16'hABCD;
    push_frame(2'd3, 16'hABCD);
    pulse_start();
    n = 0;
    while (!(rows == 3 && cam_href && byte_cnt == 10) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("t6_mid_row_reached", {31'd0, cam_href}, 1);
    rst = 1'b1;
    mon_en = 1'b0;
    @(negedge clk);
    check("t6_abort_outputs", {22'd0, cam_vsync, cam_href, cam_data}, 0);
    check("t6_abort_busy_done", {30'd0, busy, frame_done}, 0);
    check("t6_abort_count", {24'd0, frame_count}, 0);
    check("t6_abort_pclk", {31'd0, cam_pclk}, 0);
    rst = 1'b0;
    exp_q.delete();
    clear_stats();
    href_slot_q = 1'b0;
    fd_before = fd_total;
    mon_en = 1'b1;
    repeat (1200) @(negedge clk);
    check("t6_no_done_after_abort", fd_total - fd_before, 0);
    check("t6_busy_idle", {31'd0, busy}, 0);
    clear_stats();
    color_in = 16'h1234;
    push_frame(2'd3, 16'h1234);
    pulse_start();
    wait_fd("t6", 1200);
    check("t6_count", {24'd0, frame_count}, 1);
    end_of_frame("t6", 10);
    check("t6_row4_px0_hi", {24'd0, cap[4][0]}, 32'h12);
    check("t6_row0_px4_lo", {24'd0, cap[0][9]}, 32'h34);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
